// File: rtl/uart_pkg.sv
// Shared definitions for the uart_6809 register block: register bit positions,
// the common TX/RX state encoding and default configuration values.
package uart_pkg;

    localparam int STAT_RX_READY    = 0;
    localparam int STAT_TX_NOT_FULL = 1;
    localparam int STAT_TX_IDLE     = 2;
    localparam int STAT_RX_OVERRUN  = 3;
    localparam int STAT_FRAME_ERR   = 4;
    localparam int STAT_TX_OVR      = 5;

    localparam int CTRL_RIE     = 0;
    localparam int CTRL_TIE     = 1;
    localparam int CTRL_LOOP    = 6;
    localparam int CTRL_CLR_ERR = 7;

    localparam int DEFAULT_CLKS_PER_BIT  = 104;
    localparam int DEFAULT_TX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    function automatic logic [7:0] status_byte(
        input logic rx_ready,
        input logic tx_not_full,
        input logic tx_idle,
        input logic rx_overrun,
        input logic frame_err,
        input logic tx_ovr
    );
        logic [7:0] s;
        s                   = '0;
        s[STAT_RX_READY]    = rx_ready;
        s[STAT_TX_NOT_FULL] = tx_not_full;
        s[STAT_TX_IDLE]     = tx_idle;
        s[STAT_RX_OVERRUN]  = rx_overrun;
        s[STAT_FRAME_ERR]   = frame_err;
        s[STAT_TX_OVR]      = tx_ovr;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receive deserializer: 2-flop synchronizer, false-start filter, mid-bit sampling.
// With UART_LOOPBACK_EN defined, the line can be taken from the local TX shifter instead.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
`ifdef UART_LOOPBACK_EN
    input  logic       loop,
    input  logic       loop_line,
`endif
    output logic [7:0] data,
    output logic       done,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          line;
    logic          line_q;
    uart_state_t   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tick;

    // Synchronizer resets to the idle (high) level so reset release is not seen as a start edge.
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

`ifdef UART_LOOPBACK_EN
    assign line = loop ? loop_line : sync[1];
`else
    assign line = sync[1];
`endif

    assign tick = (clk_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            line_q  <= 1'b1;
        end else begin
            line_q <= line;
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (line_q && !line) state <= ST_START;
                end
                ST_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= line ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        shift   <= {line, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion pulses are decoded from the stop-bit sample so the top can register them directly.
    assign data      = shift;
    assign done      = (state == ST_STOP) && tick && line;
    assign frame_err = (state == ST_STOP) && tick && !line;

endmodule

// File: rtl/uart_6809.sv
// Memory-mapped 8N1 UART for the 6809 bus: TX FIFO + shifter, RX holding register, sticky errors, IRQ.
// Optional feature macro: UART_LOOPBACK_EN (CONTROL bit 6 routes TX back into RX and holds o_tx high).
module uart_6809
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int TX_FIFO_DEPTH = DEFAULT_TX_FIFO_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_data_ce,
    input  logic       i_uart_status_ce,
    input  logic       i_uart_control_ce,
    input  logic       i_valid,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_irq
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    logic data_wr, data_rd, ctrl_wr, clr_err;

    assign data_wr = i_valid && i_uart_data_ce && !i_rw;
    assign data_rd = i_valid && i_uart_data_ce && i_rw;
    assign ctrl_wr = i_valid && i_uart_control_ce && !i_rw;
    assign clr_err = ctrl_wr && i_data[CTRL_CLR_ERR];

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [7:0]  fifo_head;

    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_line;
    logic          tx_tick;
    logic          tx_idle;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    assign tx_tick = (tx_cnt == BIT_LAST);
    assign pop     = !fifo_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tick));
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
    assign push    = data_wr && (!fifo_full || pop);
    assign tx_idle = fifo_empty && (tx_state == ST_IDLE);

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX shifter ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_state <= ST_START;
                        tx_shift <= fifo_head;
                        tx_line  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= ST_DATA;
                        tx_line  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_bit   <= '0;
                            tx_state <= ST_STOP;
                            tx_line  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (pop) begin
                            tx_state <= ST_START;
                            tx_shift <= fifo_head;
                            tx_line  <= 1'b0;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic [7:0] rx_byte;
    logic       rx_done, rx_ferr;
    logic       ctrl_loop;

    uart_rx_deser #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rx       (i_rx),
`ifdef UART_LOOPBACK_EN
        .loop     (ctrl_loop),
        .loop_line(tx_line),
`endif
        .data     (rx_byte),
        .done     (rx_done),
        .frame_err(rx_ferr)
    );

    // ---------------- Registers ----------------
    logic [7:0] rx_hold;
    logic       rx_ready, rx_overrun, frame_err, tx_ovr;
    logic       ctrl_rie, ctrl_tie;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_hold    <= '0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_ovr     <= 1'b0;
            ctrl_rie   <= 1'b0;
            ctrl_tie   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_rie <= i_data[CTRL_RIE];
                ctrl_tie <= i_data[CTRL_TIE];
            end

            // A read that coincides with a completion frees the register for the new byte.
            if (rx_done) begin
                if (!rx_ready || data_rd) begin
                    rx_hold  <= rx_byte;
                    rx_ready <= 1'b1;
                end
            end else if (data_rd) begin
                rx_ready <= 1'b0;
            end

            // Error events take priority over a coincident sticky clear.
            if (rx_done && rx_ready && !data_rd) rx_overrun <= 1'b1;
            else if (clr_err)                    rx_overrun <= 1'b0;

            if (rx_ferr)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;

            if (data_wr && !push) tx_ovr <= 1'b1;
            else if (clr_err)     tx_ovr <= 1'b0;
        end
    end

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     ctrl_loop <= 1'b0;
        else if (ctrl_wr) ctrl_loop <= i_data[CTRL_LOOP];
    end

    assign o_tx = ctrl_loop ? 1'b1 : tx_line;
`else
    assign ctrl_loop = 1'b0;
    assign o_tx      = tx_line;
`endif

    // ---------------- Read mux and IRQ ----------------
    logic [7:0] ctrl_byte;
    logic [7:0] stat_byte;

    assign stat_byte = status_byte(rx_ready, !fifo_full, tx_idle, rx_overrun, frame_err, tx_ovr);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ctrl_byte           = '0;
        ctrl_byte[CTRL_RIE] = ctrl_rie;
        ctrl_byte[CTRL_TIE] = ctrl_tie;
`ifdef UART_LOOPBACK_EN
        ctrl_byte[CTRL_LOOP] = ctrl_loop;
`endif
    end

    always_comb begin
        o_data = '0;
        if (i_uart_data_ce)         o_data = rx_hold;
        else if (i_uart_status_ce)  o_data = stat_byte;
        else if (i_uart_control_ce) o_data = ctrl_byte;
    end

    assign o_irq = (ctrl_rie && rx_ready) || (ctrl_tie && tx_idle);

endmodule

// File: tb/tb_uart_6809.sv
// Self-checking bench for uart_6809: register vector table, TX frame scoreboard, hand-built RX sequences.
module tb_uart_6809;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_ce, status_ce, control_ce, valid, rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rx;
    logic       tx;
    logic       irq;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic        mon_en = 1'b1;
    logic [7:0]  tx_exp [$];
    logic [7:0]  rx_exp [$];
    int unsigned frame_starts [$];

    uart_6809 #(
        .CLKS_PER_BIT (CPB),
        .TX_FIFO_DEPTH(4)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_uart_data_ce   (data_ce),
        .i_uart_status_ce (status_ce),
        .i_uart_control_ce(control_ce),
        .i_valid          (valid),
        .i_rw             (rw),
        .i_data           (wdata),
        .o_data           (rdata),
        .i_rx             (rx),
        .o_tx             (tx),
        .o_irq            (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_DATA, SEL_STATUS, SEL_CTRL} sel_t;

    typedef struct packed {
        sel_t       sel;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic set_sel(input sel_t s);
        data_ce    = (s == SEL_DATA);
        status_ce  = (s == SEL_STATUS);
        control_ce = (s == SEL_CTRL);
    endtask

    // One-cycle bus strobe; read data is sampled mid-cycle, before the side-effect edge.
    task automatic bus_access(input sel_t s, input logic r, input logic [7:0] d, output logic [7:0] q);
        @(posedge clk);
        #1;
        set_sel(s);
        rw    = r;
        wdata = d;
        valid = 1'b1;
        @(negedge clk);
        q = rdata;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rw    = 1'b1;
        set_sel(SEL_NONE);
    endtask

    task automatic bus_write(input sel_t s, input logic [7:0] d);
        logic [7:0] q;
        bus_access(s, 1'b0, d, q);
    endtask

    task automatic status_check(input string name, input logic [7:0] expected);
        logic [7:0] q;
        bus_access(SEL_STATUS, 1'b1, 8'h00, q);
        check(name, q, expected);
    endtask

    task automatic rx_read_check(input string name);
        logic [7:0] q;
        bus_access(SEL_DATA, 1'b1, 8'h00, q);
        if (rx_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got 0x%0h expected no byte", name, q);
        end else begin
            check(name, q, rx_exp.pop_front());
        end
    endtask

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1;
        rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // TX scoreboard: decode every frame on o_tx at mid-bit and compare with the queued byte.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
                frame_starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                check("tx_start_mid", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", tx, 1'b1);
                if (tx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", b);
                end else begin
                    check("tx_byte", b, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [7:0]  q;
        logic [7:0]  b2b [6];
        logic        prev;
        int unsigned last;
        int          nchg;

        rst_n = 1'b0;
        valid = 1'b0;
        rw    = 1'b1;
        wdata = 8'h00;
        rx    = 1'b1;
        set_sel(SEL_NONE);

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_irq", irq, 1'b0);
        check("reset_data", rdata, 8'h00);
        rst_n = 1'b1;

        // ---------------- register table ----------------
        vecs = '{
            '{SEL_STATUS, 1'b1, 8'h00, 8'h06, 1'b0},
            '{SEL_CTRL,   1'b1, 8'h00, 8'h00, 1'b0},
            '{SEL_DATA,   1'b1, 8'h00, 8'h00, 1'b0},
            '{SEL_NONE,   1'b1, 8'h00, 8'h00, 1'b0},
            '{SEL_CTRL,   1'b0, 8'hFF, 8'h00, 1'b0},
            '{SEL_CTRL,   1'b1, 8'h00, 8'h03, 1'b1},
            '{SEL_STATUS, 1'b0, 8'hFF, 8'h00, 1'b0},
            '{SEL_STATUS, 1'b1, 8'h00, 8'h06, 1'b1},
            '{SEL_CTRL,   1'b0, 8'h01, 8'h00, 1'b0},
            '{SEL_CTRL,   1'b1, 8'h00, 8'h01, 1'b0},
            '{SEL_CTRL,   1'b0, 8'h00, 8'h00, 1'b0},
            '{SEL_STATUS, 1'b1, 8'h00, 8'h06, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            bus_access(vecs[i].sel, vecs[i].rd, vecs[i].wd, q);
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_data", i), q, vecs[i].exp_data);
                check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
            end
        end

        // ---------------- single TX frame, 0x55 ----------------
        tx_exp.push_back(8'h55);
        bus_write(SEL_DATA, 8'h55);
        @(negedge clk);
        check("tx_latency_pre", tx, 1'b1);
        @(negedge clk);
        check("tx_latency_start", tx, 1'b0);
        last = cyc;
        prev = 1'b0;
        nchg = 0;
        for (int i = 0; i < 1200 && nchg < 9; i++) begin
            @(negedge clk);
            if (tx !== prev) begin
                check($sformatf("tx_bit%0d_width", nchg), cyc - last, CPB);
                last = cyc;
                prev = tx;
                nchg++;
            end
        end
        check("tx_transitions", nchg, 9);
        repeat (88) @(negedge clk);
        status_check("tx_busy_status", 8'h02);
        repeat (20) @(negedge clk);
        status_check("tx_idle_status", 8'h06);

        // ---------------- back-to-back TX with FIFO overflow ----------------
        frame_starts.delete();
        b2b = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hA5, 8'h66};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_exp.push_back(b2b[i]);
            bus_write(SEL_DATA, b2b[i]);
        end
        status_check("fifo_full_status", 8'h20);
        for (int i = 0; i < 8000 && tx_exp.size() != 0; i++) @(negedge clk);
        check("tx_drain", tx_exp.size(), 0);
        repeat (CPB) @(negedge clk);
        check("b2b_frames", frame_starts.size(), 5);
        for (int i = 1; i < frame_starts.size(); i++)
            check($sformatf("b2b_gap%0d", i), frame_starts[i] - frame_starts[i-1], 10 * CPB);
        status_check("tx_ovr_sticky", 8'h26);
        bus_write(SEL_CTRL, 8'h80);
        status_check("tx_ovr_cleared", 8'h06);

        // ---------------- RX 0xA3 with RIE ----------------
        bus_write(SEL_CTRL, 8'h01);
        rx_exp.push_back(8'hA3);
        send_rx(8'hA3, 1'b1);
        check("rx_irq_set", irq, 1'b1);
        status_check("rx_ready_status", 8'h07);
        rx_read_check("rx_a3");
        check("rx_irq_drop", irq, 1'b0);

        // ---------------- RX overrun ----------------
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        send_rx(8'hC5, 1'b1);
        status_check("rx_overrun_status", 8'h0F);
        rx_read_check("rx_overrun_keep_first");
        status_check("rx_after_read", 8'h0E);
        bus_write(SEL_CTRL, 8'h80);
        status_check("rx_overrun_cleared", 8'h06);

        // ---------------- framing error ----------------
        send_rx(8'h5A, 1'b0);
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        status_check("frame_err_status", 8'h16);
        bus_write(SEL_CTRL, 8'h80);
        status_check("frame_err_cleared", 8'h06);

        // ---------------- false start glitch, then a clean frame ----------------
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        status_check("glitch_ignored", 8'h06);
        rx_exp.push_back(8'h96);
        send_rx(8'h96, 1'b1);
        status_check("post_glitch_ready", 8'h07);
        rx_read_check("rx_96");

        // ---------------- reset in the middle of a frame ----------------
        mon_en = 1'b0;
        bus_write(SEL_DATA, 8'h00);
        repeat (10) @(negedge clk);
        check("midframe_tx_low", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midframe_async_tx", tx, 1'b1);
        check("midframe_irq", irq, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        status_check("post_reset_status", 8'h06);
        repeat (2 * CPB) @(negedge clk);
        check("post_reset_tx_idle", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
